// File: rtl/fma_pkg.sv
// Shared types and constants for the FMA flag/special-case pipeline.
//   - Flag bit indices in RISC-V fflags order {NV,DZ,OF,UF,NX}
//   - rm_t: the two-bit rounding-mode encoding used by the datapath
//   - flags_t: packed per-operation exception flags
//   - qnan/maxfinite/inf: encodings for a 1+ew+mw bit format, returned
//     right-aligned in a 64-bit container with the sign bit clear.
package fma_pkg;

  localparam int unsigned FlagNv = 4;
  localparam int unsigned FlagDz = 3;
  localparam int unsigned FlagOf = 2;
  localparam int unsigned FlagUf = 1;
  localparam int unsigned FlagNx = 0;

  localparam int unsigned MaxFw = 64;

  typedef logic [MaxFw-1:0] fp_bits_t;

  typedef enum logic [1:0] {
    RmRz  = 2'b00,
    RmRne = 2'b01,
    RmRdn = 2'b10,
    RmRup = 2'b11
  } rm_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } flags_t;

  // Canonical quiet NaN: all-ones exponent, mantissa MSB set.
  function automatic fp_bits_t qnan(int unsigned ew, int unsigned mw);
    return (((fp_bits_t'(1) << ew) - fp_bits_t'(1)) << mw) | (fp_bits_t'(1) << (mw - 1));
  endfunction

  // Largest finite magnitude: exponent all-ones minus one, mantissa all ones.
  function automatic fp_bits_t maxfinite(int unsigned ew, int unsigned mw);
    return (((fp_bits_t'(1) << ew) - fp_bits_t'(2)) << mw) | ((fp_bits_t'(1) << mw) - fp_bits_t'(1));
  endfunction

  function automatic fp_bits_t inf(int unsigned ew, int unsigned mw);
    return ((fp_bits_t'(1) << ew) - fp_bits_t'(1)) << mw;
  endfunction

endpackage

// File: rtl/fma_special_case.sv
// Combinational special-case resolution for the FMA result.
// Resolves NaN/Inf propagation, invalid operations and overflow, then
// produces the final result and this operation's exception flags.
// Ports:
//   in_sign/in_snan/in_nan/in_inf/in_zero  per-operand class bits {X,Y,Z}
//   in_rm                                  rounding mode (rm_t encoding)
//   in_result                              rounded datapath result
//   in_exp                                 signed normalised exponent
//   in_guard/in_round/in_sticky            rounding bits
//   out_result/out_flags                   resolved result and flags
module fma_special_case
  import fma_pkg::*;
#(
  parameter int unsigned EW = 5,
  parameter int unsigned MW = 10
) (
  input  logic [2:0]     in_sign,
  input  logic [2:0]     in_snan,
  input  logic [2:0]     in_nan,
  input  logic [2:0]     in_inf,
  input  logic [2:0]     in_zero,
  input  logic [1:0]     in_rm,
  input  logic [EW+MW:0] in_result,
  input  logic [EW+1:0]  in_exp,
  input  logic           in_guard,
  input  logic           in_round,
  input  logic           in_sticky,
  output logic [EW+MW:0] out_result,
  output flags_t         out_flags
);

  localparam int unsigned FW = 1 + EW + MW;

  localparam fp_bits_t QnanAll = qnan(EW, MW);
  localparam fp_bits_t MaxAll  = maxfinite(EW, MW);
  localparam fp_bits_t InfAll  = inf(EW, MW);

  localparam logic [FW-1:0] Qnan = QnanAll[FW-1:0];
  localparam logic [FW-1:0] Maxf = MaxAll[FW-1:0];
  localparam logic [FW-1:0] Inf  = InfAll[FW-1:0];

  // Smallest exponent that no longer fits a finite encoding.
  localparam logic [EW+1:0] ExpOvf = {2'b00, {EW{1'b1}}};

  logic x_inf, y_inf, z_inf, x_zero, y_zero;
  logic x_sign, y_sign, z_sign, prod_sign;
  logic res_sign, ovf, exp_le0, inexact;
  logic unused_z_zero;

  assign x_inf  = in_inf[2];
  assign y_inf  = in_inf[1];
  assign z_inf  = in_inf[0];
  assign x_zero = in_zero[2];
  assign y_zero = in_zero[1];
  assign x_sign = in_sign[2];
  assign y_sign = in_sign[1];
  assign z_sign = in_sign[0];
  assign prod_sign = x_sign ^ y_sign;

  // A zero addend never changes the special-case outcome.
  assign unused_z_zero = in_zero[0];

  assign res_sign = in_result[FW-1];
  assign ovf      = $signed(in_exp) >= $signed(ExpOvf);
  assign exp_le0  = in_exp[EW+1] | (in_exp == '0);
  assign inexact  = in_guard | in_round | in_sticky | ovf;

  always_comb begin
    out_result = in_result;
    out_flags  = '0;
    if (|in_snan) begin
      out_result   = Qnan;
      out_flags.nv = 1'b1;
    end else if (|in_nan) begin
      out_result = Qnan;
    end else if ((x_inf | y_inf) & z_inf & (prod_sign ^ z_sign)) begin
      // inf - inf
      out_result   = Qnan;
      out_flags.nv = 1'b1;
    end else if ((x_inf & y_zero) | (x_zero & y_inf)) begin
      out_result   = Qnan;
      out_flags.nv = 1'b1;
    end else if (x_inf | y_inf) begin
      out_result = {prod_sign, Inf[FW-2:0]};
    end else if (z_inf) begin
      out_result = {z_sign, Inf[FW-2:0]};
    end else begin
      out_flags.of = ovf;
      out_flags.nx = inexact;
      out_flags.uf = exp_le0 & inexact;
      if (ovf) begin
        unique case (rm_t'(in_rm))
          RmRz:    out_result = {res_sign, Maxf[FW-2:0]};
          RmRne:   out_result = {res_sign, Inf[FW-2:0]};
          RmRdn:   out_result = res_sign ? {1'b1, Inf[FW-2:0]} : {1'b0, Maxf[FW-2:0]};
          RmRup:   out_result = res_sign ? {1'b1, Maxf[FW-2:0]} : {1'b0, Inf[FW-2:0]};
          default: out_result = in_result;
        endcase
      end
    end
  end

endmodule

// File: rtl/fma_flags_pipe.sv
// Registered FMA special-case/flag stage.
// Resolves the FMA result through fma_special_case, holds it in a one-entry
// valid/ready output register and accrues exception flags into fflags
// (RISC-V order {NV,DZ,OF,UF,NX}), which software may overwrite.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid/in_ready              input handshake
//   in_*                           operand classes, rm, result, exponent, GRS
//   out_valid/out_ready            output handshake
//   out_result/out_flags           registered result and per-op flags
//   fflags, flags_we, flags_wdata  accrued flags and software write port
//   irq_mask, irq                  only when FMA_FLAGS_IRQ_EN is defined:
//                                  registered interrupt on masked fflags
module fma_flags_pipe
  import fma_pkg::*;
#(
  parameter int unsigned EW = 5,
  parameter int unsigned MW = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_sign,
  input  logic [2:0]     in_snan,
  input  logic [2:0]     in_nan,
  input  logic [2:0]     in_inf,
  input  logic [2:0]     in_zero,
  input  logic [1:0]     in_rm,
  input  logic [EW+MW:0] in_result,
  input  logic [EW+1:0]  in_exp,
  input  logic           in_guard,
  input  logic           in_round,
  input  logic           in_sticky,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] out_result,
  output logic [4:0]     out_flags,
  output logic [4:0]     fflags,
`ifdef FMA_FLAGS_IRQ_EN
  input  logic [4:0]     irq_mask,
  output logic           irq,
`endif
  input  logic           flags_we,
  input  logic [4:0]     flags_wdata
);

  localparam int unsigned FW = 1 + EW + MW;

  logic [FW-1:0] sc_result;
  flags_t        sc_flags;

  logic          out_valid_q, out_valid_d;
  logic [FW-1:0] out_result_q;
  flags_t        out_flags_q;
  flags_t        fflags_q, fflags_d;
  logic          capture, accrue;

  assign in_ready = ~out_valid_q | out_ready;
  assign capture  = in_valid & in_ready;
  assign accrue   = out_valid_q & out_ready;

  fma_special_case #(
    .EW(EW),
    .MW(MW)
  ) u_special_case (
    .in_sign   (in_sign),
    .in_snan   (in_snan),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .in_rm     (in_rm),
    .in_result (in_result),
    .in_exp    (in_exp),
    .in_guard  (in_guard),
    .in_round  (in_round),
    .in_sticky (in_sticky),
    .out_result(sc_result),
    .out_flags (sc_flags)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    if (capture) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A software write never drops flags from an op retiring in the same cycle.
  always_comb begin
    fflags_d = fflags_q;
    if (flags_we) begin
      fflags_d = flags_t'(flags_wdata | (accrue ? out_flags_q : flags_t'('0)));
    end else if (accrue) begin
      fflags_d = flags_t'(fflags_q | out_flags_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      fflags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      fflags_q    <= fflags_d;
      if (capture) begin
        out_result_q <= sc_result;
        out_flags_q  <= sc_flags;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign fflags     = fflags_q;

`ifdef FMA_FLAGS_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(fflags_q & irq_mask);
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/fma_flags_pipe.md
Name: fma_flags_pipe

Overview:
- Parametrised, registered successor to the FMA special-case/flag stage.
- Takes the pre-rounded FMA result plus operand classification, resolves NaN/Inf/overflow, and generates IEEE-754 exception flags.
- Holds the result in a one-entry valid/ready output stage and maintains an accrued-flag register (fflags, RISC-V bit order) that software can read and write.
- Sits between the FMA rounding datapath and the writeback/CSR logic.

Parameters:
- EW, 5, exponent width (5 = half, 8 = single/bfloat16).
- MW, 10, stored mantissa width.
- FW is derived, not a parameter: FW = 1+EW+MW.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  stage can accept an input
- in_sign  in  3  operand signs {X,Y,Z}
- in_snan  in  3  signalling-NaN per operand {X,Y,Z}
- in_nan  in  3  any-NaN per operand
- in_inf  in  3  infinity per operand
- in_zero  in  3  zero per operand
- in_rm  in  2  rounding mode: 00 RZ, 01 RNE, 10 RDN, 11 RUP
- in_result  in  FW  rounded datapath result (sign valid)
- in_exp  in  EW+2  signed normalised exponent, before the overflow check
- in_guard, in_round, in_sticky  in  1 each  rounding bits
- out_valid  out  1  output valid
- out_ready  in  1  consumer accepts output
- out_result  out  FW  final result
- out_flags  out  5  flags for this op {NV,DZ,OF,UF,NX}
- fflags  out  5  accrued flags
- flags_we  in  1  software write of fflags
- flags_wdata  in  5  write data

Behaviour:
- Reset (async): out_valid=0, out_result=0, out_flags=0, fflags=0; in_ready=1 after reset deasserts.
- Any in-flight op is discarded on reset.
- Handshake: in_ready = ~out_valid | out_ready. Input is captured when in_valid & in_ready.
- Latency: exactly 1 cycle; the result is visible the cycle after capture.
- out_* are held stable while out_valid & ~out_ready.
- out_valid clears on out_ready unless a new capture happens in the same cycle. Back-to-back ops run at full throughput.
- Resolution priority, first match wins; qNaN = {0, all-ones exp, 1, zeros}:
  1. Any snan: result qNaN, NV=1.
  2. Any nan: result qNaN, no flags.
  3. (X or Y inf) & Z inf & (Xs^Ys^Zs): result qNaN, NV=1.
  4. Inf×zero, X with Y either way: result qNaN, NV=1.
  5. X or Y inf: result inf with sign Xs^Ys.
  6. Z inf: result inf with sign Zs.
  7. Overflow, signed in_exp >= 2^EW-1: OF=1, NX=1. Result by sign s and in_rm:
     - RNE: inf.
     - RZ: max-finite.
     - RDN: -inf if s=1, else +max-finite.
     - RUP: +inf if s=0, else -max-finite.
  8. Otherwise: result = in_result.
- Flags outside the special cases (1–6):
  - NX = G|R|S|OF.
  - UF = (signed in_exp <= 0) & NX.
- DZ is always 0. Special cases 1–6 force NX=UF=OF=0.
- Accrual: on the output handshake (out_valid & out_ready), fflags |= out_flags.
- flags_we in the same cycle as an accrual: fflags = flags_wdata | out_flags, so no event is lost.
- flags_we alone: fflags = flags_wdata.

Optional Feature:
- Macro: FMA_FLAGS_IRQ_EN.
- When defined, adds ports irq_mask (in, 5) and irq (out, 1).
- irq is registered: irq = |(fflags & irq_mask), updated every cycle. Reset value is 0.
- irq clears the cycle after software clears fflags.
- When undefined: no extra ports and no extra logic.

Decomposition:
- Package fma_pkg holds:
  - flag index constants NV=4, DZ=3, OF=2, UF=1, NX=0;
  - the rm_t enum;
  - a flags_t packed struct;
  - functions qnan(EW,MW), maxfinite(EW,MW) and inf(EW,MW).
- Sub-module fma_special_case: purely combinational resolution of the result and out_flags, instantiated ahead of the output register.
- The top level holds the handshake, the output register, fflags and irq.

Test Plan (EW=5, MW=10):
- X=inf, Y=0, Z=1.0, RNE -> out_result 0x7E00, out_flags 10000; fflags=10000 after the handshake.
- in_exp=31, sign 0, RZ -> 0x7BFF, flags 00101. Same case with RNE -> 0x7C00. Sign 1 with RUP -> 0xFBFF.
- in_exp=0, sticky=1 -> flags 00011. in_exp=0, G=R=S=0 -> flags 00000.
- out_ready low for 3 cycles with in_valid high -> in_ready=0, out_* stable, fflags unchanged. out_ready rises -> accrue once, next op captured the same cycle.
- flags_we=1, wdata=00001, concurrent with a handshake carrying 10000 -> fflags=10001.
- Assert reset while out_valid=1 -> out_valid, fflags (and irq) read 0 immediately; the held result is never accepted.
